// File: rtl/alu16_seq.sv
// ---------------------------------------------------------------------------
// alu16_seq
//   Sequencer that runs a 4*NNIB-bit operation on an external 4-bit
//   combinational ALU. It issues one nibble per cycle, least significant
//   nibble first, and chains the carry between nibbles. One operation takes
//   NNIB RUN cycles plus one DONE cycle.
//
// Ports
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   start, op, a, b, cin    command request and operands; sampled when idle
//                           or in DONE
//                           op: 000 ADD, 001 ADDC, 01x ADD, 1xx LOGIC(op[1:0])
//   alu_a, alu_b            operand nibbles driven to the ALU
//   alu_c_in, alu_op, alu_l carry, ALUOP and logic-select driven to the ALU
//   alu_r, alu_zero,        result and flags returned by the ALU
//   alu_c_out, alu_sign
//   result, zero, c_out,    last completed result and flags
//   sign
//   busy                    operation in progress
//   done                    one-cycle completion pulse
// ---------------------------------------------------------------------------
module alu16_seq #(
    parameter int NNIB = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [4*NNIB-1:0] a,
    input  logic [4*NNIB-1:0] b,
    input  logic              cin,
    output logic [3:0]        alu_a,
    output logic [3:0]        alu_b,
    output logic              alu_c_in,
    output logic [1:0]        alu_op,
    output logic              alu_l,
    input  logic [3:0]        alu_r,
    input  logic              alu_zero,
    input  logic              alu_c_out,
    input  logic              alu_sign,
    output logic [4*NNIB-1:0] result,
    output logic              zero,
    output logic              c_out,
    output logic              sign,
    output logic              busy,
    output logic              done
);

    localparam int W  = 4 * NNIB;
    localparam int KW = (NNIB > 1) ? $clog2(NNIB) : 1;

    // ALUOP value the ALU expects for addition.
    localparam logic [1:0] ALUOP_ADD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    logic [KW-1:0]   k;          // nibble currently presented to the ALU
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            logic_mode; // captured op[2]
    logic            carry;      // carry into the current nibble
    logic            zero_acc;   // AND of alu_zero over the nibbles so far
    logic [W-1:0]    work;

    logic            last_nib;
    logic [W-1:0]    work_next;
    logic [3:0]      next_a;
    logic [3:0]      next_b;
    logic            accept_carry;

    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and no latch is inferred.
    always_comb begin
        last_nib  = (k == KW'(NNIB - 1));
        work_next = work;
        work_next[4*int'(k) +: 4] = alu_r;
        next_a = '0;
        next_b = '0;
        if (!last_nib) begin
            next_a = a_reg[4*(int'(k) + 1) +: 4];
            next_b = b_reg[4*(int'(k) + 1) +: 4];
        end
        // Only ADDC brings an external carry into nibble 0.
        accept_carry = (op == 3'b001) && cin;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            k          <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            logic_mode <= 1'b0;
            carry      <= 1'b0;
            zero_acc   <= 1'b0;
            work       <= '0;
            result     <= '0;
            zero       <= 1'b0;
            c_out      <= 1'b0;
            sign       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_c_in   <= 1'b0;
            alu_op     <= '0;
            alu_l      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // DONE behaves like IDLE for accepting, which gives
                    // back-to-back operations every 5 cycles.
                    done <= 1'b0;
                    if (start) begin
                        state      <= S_RUN;
                        k          <= '0;
                        a_reg      <= a;
                        b_reg      <= b;
                        logic_mode <= op[2];
                        carry      <= accept_carry;
                        zero_acc   <= 1'b1;
                        busy       <= 1'b1;
                        alu_a      <= a[3:0];
                        alu_b      <= b[3:0];
                        alu_l      <= op[2];
                        alu_op     <= op[2] ? op[1:0] : ALUOP_ADD;
                        alu_c_in   <= op[2] ? 1'b0 : accept_carry;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_RUN: begin
                    work     <= work_next;
                    carry    <= alu_c_out;
                    zero_acc <= zero_acc & alu_zero;
                    if (last_nib) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        result   <= work_next;
                        zero     <= zero_acc & alu_zero;
                        sign     <= alu_sign;
                        c_out    <= logic_mode ? 1'b0 : alu_c_out;
                        alu_a    <= '0;
                        alu_b    <= '0;
                        alu_c_in <= 1'b0;
                        alu_op   <= '0;
                        alu_l    <= 1'b0;
                    end else begin
                        k        <= k + 1'b1;
                        alu_a    <= next_a;
                        alu_b    <= next_b;
                        // Logic ops ignore the carry chain entirely.
                        alu_c_in <= logic_mode ? 1'b0 : alu_c_out;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu16_seq.sv
// ---------------------------------------------------------------------------
// tb_alu16_seq
//   Self-checking bench for alu16_seq. A behavioural 4-bit ALU (or an XOR
//   stub) closes the loop; expected values come from a 16-bit reference
//   model computed with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_alu16_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  op_i;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        cin_i;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic        alu_c_in;
    logic [1:0]  alu_op;
    logic        alu_l;
    logic [3:0]  alu_r;
    logic        alu_zero;
    logic        alu_c_out;
    logic        alu_sign;
    logic [15:0] result;
    logic        zero;
    logic        c_out;
    logic        sign;
    logic        busy;
    logic        done;

    logic        stub = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    alu16_seq #(.NNIB(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op_i),
        .a         (a_i),
        .b         (b_i),
        .cin       (cin_i),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c_in  (alu_c_in),
        .alu_op    (alu_op),
        .alu_l     (alu_l),
        .alu_r     (alu_r),
        .alu_zero  (alu_zero),
        .alu_c_out (alu_c_out),
        .alu_sign  (alu_sign),
        .result    (result),
        .zero      (zero),
        .c_out     (c_out),
        .sign      (sign),
        .busy      (busy),
        .done      (done)
    );

    // Behavioural 4-bit ALU: l=0 adds, l=1 selects AND/OR/XOR/NOT-A.
    logic [4:0] sum5;
    always_comb begin
        sum5      = '0;
        alu_r     = '0;
        alu_c_out = 1'b0;
        if (stub) begin
            alu_r = alu_a ^ alu_b;
        end else if (!alu_l) begin
            sum5      = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_c_in};
            alu_r     = sum5[3:0];
            alu_c_out = sum5[4];
        end else begin
            case (alu_op)
                2'b00:   alu_r = alu_a & alu_b;
                2'b01:   alu_r = alu_a | alu_b;
                2'b10:   alu_r = alu_a ^ alu_b;
                default: alu_r = ~alu_a;
            endcase
        end
        alu_zero = (alu_r == 4'h0);
        alu_sign = alu_r[3];
    end

    typedef struct packed {
        logic [15:0] r;
        logic        c;
        logic        z;
        logic        s;
    } res_t;

    function automatic res_t model(input logic [2:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic cin);
        res_t        m;
        logic [16:0] s;
        m = '0;
        if (op[2]) begin
            case (op[1:0])
                2'b00:   m.r = a & b;
                2'b01:   m.r = a | b;
                2'b10:   m.r = a ^ b;
                default: m.r = ~a;
            endcase
            m.c = 1'b0;
        end else begin
            s   = {1'b0, a} + {1'b0, b} + {16'b0, (op == 3'b001) ? cin : 1'b0};
            m.r = s[15:0];
            m.c = s[16];
        end
        m.z = (m.r == 16'h0);
        m.s = m.r[15];
        return m;
    endfunction

    // Carry that must enter nibble k: the carry out of the low 4k bits.
    function automatic logic exp_carry(input logic [2:0] op, input logic [15:0] a,
                                       input logic [15:0] b, input logic cin,
                                       input int k);
        logic [16:0] mask;
        logic [16:0] s;
        logic        c0;
        if (op[2]) return 1'b0;
        c0 = (op == 3'b001) && cin;
        if (k == 0) return c0;
        mask = (17'd1 << (4 * k)) - 17'd1;
        s    = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {16'b0, c0};
        return s[4*k];
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " busy"},   32'(busy),   32'd0);
        check({tag, " done"},   32'(done),   32'd0);
        check({tag, " result"}, 32'(result), 32'd0);
        check({tag, " flags"},  32'({zero, c_out, sign}), 32'd0);
        check({tag, " alu"},    32'({alu_a, alu_b, alu_c_in, alu_op, alu_l}), 32'd0);
    endtask

    // One complete operation from an idle DUT, checking every RUN cycle.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic cin);
        res_t m;
        m = model(op, a, b, cin);
        @(negedge clk);
        start = 1'b1; op_i = op; a_i = a; b_i = b; cin_i = cin;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                // Inputs may change freely after accept.
                start = 1'b0;
                a_i   = 16'($urandom);
                b_i   = 16'($urandom);
                op_i  = 3'($urandom);
                cin_i = 1'($urandom);
            end
            check({tag, " busy"}, 32'({busy, done}), 32'b10);
            check({tag, " alu_ab"}, 32'({alu_a, alu_b}), 32'({a[4*k +: 4], b[4*k +: 4]}));
            check({tag, " alu_ctl"}, 32'({alu_l, alu_op, alu_c_in}),
                  32'({op[2], op[2] ? op[1:0] : 2'b10, exp_carry(op, a, b, cin, k)}));
        end
        @(posedge clk); #1;
        check({tag, " done"}, 32'({busy, done}), 32'b01);
        check({tag, " result"}, 32'(result), 32'(m.r));
        check({tag, " zcs"}, 32'({zero, c_out, sign}), 32'({m.z, m.c, m.s}));
        check({tag, " alu_idle"}, 32'({alu_a, alu_b, alu_c_in, alu_op, alu_l}), 32'd0);
        @(posedge clk); #1;
        check({tag, " done_drop"}, 32'({busy, done}), 32'b00);
        check({tag, " hold"}, 32'(result), 32'(m.r));
    endtask

    logic [2:0]  bb_op [3];
    logic [15:0] bb_a  [3];
    logic [15:0] bb_b  [3];
    logic        bb_c  [3];

    initial begin
        res_t m;
        reset_n = 1'b0; start = 1'b0; op_i = '0; a_i = '0; b_i = '0; cin_i = 1'b0;
        #12;
        check_outputs_zero("reset");
        @(negedge clk); reset_n = 1'b1;

        // Directed cases on the behavioural ALU.
        run_op("add_ff",   3'b000, 16'h00FF, 16'h0001, 1'b0);
        run_op("add_wrap", 3'b000, 16'hFFFF, 16'h0001, 1'b0);
        run_op("addc_1",   3'b001, 16'h7FFF, 16'h0000, 1'b1);
        run_op("addc_0",   3'b001, 16'h7FFF, 16'h0000, 1'b0);
        run_op("add_cin",  3'b000, 16'h7FFF, 16'h0000, 1'b1);
        run_op("op011",    3'b011, 16'hFFFF, 16'h0001, 1'b1);

        // XOR stub: the sequencer must pass the stub result through unchanged.
        stub = 1'b1;
        run_op("stub_xor", 3'b110, 16'h1234, 16'h00FF, 1'b0);
        check("stub_const", 32'(result), 32'h12CB);
        stub = 1'b0;

        // Randomised operations.
        for (int i = 0; i < 40; i++)
            run_op("rand", 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                   1'($urandom));

        // Back-to-back with start held high: accepts at E0, E5, E10.
        for (int i = 0; i < 3; i++) begin
            bb_op[i] = 3'($urandom_range(0, 7));
            bb_a[i]  = 16'($urandom) | 16'h0100;
            bb_b[i]  = 16'($urandom);
            bb_c[i]  = 1'($urandom);
        end
        bb_op[2] = 3'b000; bb_a[2] = 16'h1234; bb_b[2] = 16'h1111;
        @(negedge clk);
        start = 1'b1; op_i = bb_op[0]; a_i = bb_a[0]; b_i = bb_b[0]; cin_i = bb_c[0];
        for (int t = 0; t < 15; t++) begin
            @(posedge clk); #1;
            if (t % 5 == 0 && t / 5 < 2) begin
                op_i = bb_op[t/5+1]; a_i = bb_a[t/5+1];
                b_i  = bb_b[t/5+1];  cin_i = bb_c[t/5+1];
            end
            check("b2b busy_done", 32'({busy, done}),
                  (t % 5 == 4) ? 32'b01 : 32'b10);
            if (t % 5 == 4) begin
                m = model(bb_op[t/5], bb_a[t/5], bb_b[t/5], bb_c[t/5]);
                check("b2b result", 32'(result), 32'(m.r));
                check("b2b zcs", 32'({zero, c_out, sign}), 32'({m.z, m.c, m.s}));
            end
            if (t == 14) start = 1'b0;
        end
        @(posedge clk); #1;
        check("b2b idle", 32'({busy, done}), 32'b00);

        // Reset in the middle of nibble 2 aborts with no done pulse.
        @(negedge clk);
        start = 1'b1; op_i = 3'b000; a_i = 16'hABCD; b_i = 16'h1111; cin_i = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        @(posedge clk); #1;
        check("abort held", 32'({busy, done}), 32'b00);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        check("abort no_done", 32'({busy, done}), 32'b00);
        run_op("post_reset", 3'b000, 16'h0003, 16'h0004, 1'b0);
        check("post_reset_const", 32'(result), 32'h0007);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu16_seq.md
Name: alu16_seq

Overview:
- Initiator (control end) for the team's 4-bit combinational ALU.
- Runs 16-bit operations by issuing four nibble operations, least significant nibble (LSN) first, with the carry chained between nibbles.
- Sits between a command source (start/op handshake) and one `alu` instance. It drives the ALU's A, B, c_in, ALUOP and l inputs and consumes its R, zero, c_out and sign outputs.

Parameters:
- NNIB, 4, number of nibbles per operation; operand width = 4*NNIB.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  command request; sampled only when busy=0
- op  in  3  command: 000 ADD, 001 ADDC, 1xx LOGIC with alu_op=op[1:0]; 010/011 execute as ADD
- a  in  16  operand A; captured on accept
- b  in  16  operand B; captured on accept
- cin  in  1  external carry for ADDC; captured on accept
- alu_a  out  4  nibble of A to the ALU
- alu_b  out  4  nibble of B to the ALU
- alu_c_in  out  1  carry to the ALU
- alu_op  out  2  ALUOP to the ALU
- alu_l  out  1  l (0 arithmetic, 1 logic) to the ALU
- alu_r  in  4  ALU result
- alu_zero  in  1  ALU zero flag
- alu_c_out  in  1  ALU carry out
- alu_sign  in  1  ALU sign flag
- result  out  16  last completed result
- zero  out  1  result==0
- c_out  out  1  final carry (arithmetic only)
- sign  out  1  result[15]
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - busy, done, result, zero, c_out, sign, carry register and all alu_* outputs = 0.
  - A reset mid-operation aborts the operation with no done pulse.
- States: IDLE, RUN (nibble counter k=0..3), DONE.
- IDLE:
  - start=1 at edge E0 captures a, b, op and cin, sets busy=1 and enters RUN with k=0.
  - Carry register = cin for ADDC, 0 otherwise.
- RUN, cycle between edges Ek and Ek+1:
  - alu_a=A[4k+3:4k], alu_b=B[4k+3:4k].
  - Arithmetic: alu_l=0, alu_op=10, alu_c_in=carry register.
  - LOGIC: alu_l=1, alu_op=op[1:0], alu_c_in=0.
  - At Ek+1: work[4k+3:4k]<=alu_r; carry<=alu_c_out; k<=k+1.
  - At E4 (after k=3): go to DONE, busy<=0.
- DONE (exactly one cycle, E4..E5):
  - done=1.
  - result=work.
  - zero = (work==0), i.e. AND of the four sampled alu_zero flags.
  - sign = alu_sign sampled on nibble 3.
  - c_out = final carry for arithmetic, 0 for LOGIC.
  - result and flags update at E4 and hold until the next completion.
  - start=1 during DONE is accepted at E5 (back-to-back); that operation's done pulses at E9.
- start while busy=1 is ignored; it is neither queued nor errored. a, b, op and cin may change freely after accept.
- alu_* outputs are 0 in IDLE and DONE.
- Latency: accept edge to done rising = 4 cycles; throughput = one operation per 5 cycles.
- Carry is unsigned; overflow is not reported separately.

Test Plan:
- Real ALU, ADD a=16'h00FF b=16'h0001 -> done at E4: result=16'h0100, c_out=0, zero=0, sign=0; busy high for exactly 4 cycles.
- ADD a=16'hFFFF b=16'h0001 -> result=16'h0000, c_out=1, zero=1, sign=0.
- ADDC a=16'h7FFF b=16'h0000 cin=1 -> result=16'h8000, sign=1, c_out=0. Repeat with cin=0 -> result=16'h7FFF.
- ALU stub (alu_r = alu_a ^ alu_b), op=110, a=16'h1234, b=16'h00FF:
  - Stub drives alu_r = a nibble XOR b nibble, not the real ALU function.
  - Per RUN cycle: alu_l=1, alu_op=10, alu_c_in=0; alu_a/alu_b = 4,3,2,1 / F,F,0,0 (LSN first).
  - result=16'h12CB, c_out=0.
- start held high continuously with new operands -> accepts at E0, E5, E10; done pulses at E4, E9, E14; no accept while busy=1.
- reset_n low during RUN k=2 -> all outputs 0 immediately with no done pulse. After release, a new ADD 16'h0003+16'h0004 -> result=16'h0007.
